instr_fetch: RTL

- Instruction fetch sequencer directly upstream of the instruction register (Register instance, DataWidth = 32).
- Reads opcode and operand bytes from memory through a ready handshake and assembles them into one instruction word.
- Issues a single active-low load strobe so the IR captures the complete instruction.
- Owns the program counter and accepts branch reloads, which abort any fetch in progress.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_len_decode.sv | 21 ++
 rtl/instr_fetch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch sequencer and, later, the
// instruction decoder:
//   - fetch_state_e       : sequencer state encoding
//   - opcode_extra_bytes  : operand byte count of an opcode (opcode[7:6]),
//                           clamped so opcode + operands fit in max_bytes
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned MAX_BYTES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        OPERAND = 2'd2,
        DONE    = 2'd3
    } fetch_state_e;

    function automatic logic [1:0] opcode_extra_bytes(
        input logic [7:0]  opcode,
        input int unsigned max_bytes = MAX_BYTES_DEFAULT
    );
        logic [1:0] extra;
        extra = opcode[7:6];
        if ({30'd0, extra} > (max_bytes - 1)) begin
            extra = 2'(max_bytes - 1);
        end
        return extra;
    endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// -----------------------------------------------------------------------------
// fetch_len_decode
// Combinational opcode -> extra (operand) byte count.
// Ports:
//   opcode_i [7:0]  first instruction byte
//   extra_o  [1:0]  number of operand bytes following the opcode
// -----------------------------------------------------------------------------
module fetch_len_decode
    import fetch_pkg::*;
#(
    parameter int unsigned MaxBytes = 4
) (
    input  logic [7:0] opcode_i,
    output logic [1:0] extra_o
);

    always_comb begin
        extra_o = opcode_extra_bytes(opcode_i, MaxBytes);
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch sequencer feeding the instruction register. Reads an opcode
// and its operand bytes through a ready handshake, assembles them into IRData
// (opcode in byte 0) and strobes IRLd_n low for one cycle. Owns the PC; a PC
// reload in any state aborts a fetch in progress.
// Ports:
//   Clk, Reset       clock, asynchronous active-low reset
//   Fetch_n          active-low fetch request (level)
//   PCLd_n, PCIn     active-low PC reload and reload value
//   MemAddr, MemRd_n memory read address and active-low read request
//   MemRdy, MemData  read data valid and read data
//   IRData, IRLd_n   assembled instruction and active-low IR load strobe
//   Len              instruction length minus one
//   PC, Busy, Fault  program counter, fetch in progress, timeout pulse
// Build option: FETCH_TIMEOUT_EN adds a memory wait limit of TimeoutCycles
// cycles; without it Fault is tied low and MemRdy is awaited indefinitely.
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned          DataWidth     = 8,
    parameter int unsigned          AddrWidth     = 16,
    parameter int unsigned          MaxBytes      = 4,
    parameter logic [AddrWidth-1:0] ResetVector   = 16'h0000,
    parameter int unsigned          TimeoutCycles = 16
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            Fetch_n,
    input  logic                            PCLd_n,
    input  logic [AddrWidth-1:0]            PCIn,
    output logic [AddrWidth-1:0]            MemAddr,
    output logic                            MemRd_n,
    input  logic                            MemRdy,
    input  logic [DataWidth-1:0]            MemData,
    output logic [DataWidth*MaxBytes-1:0]   IRData,
    output logic                            IRLd_n,
    output logic [1:0]                      Len,
    output logic [AddrWidth-1:0]            PC,
    output logic                            Busy,
    output logic                            Fault
);

    localparam int unsigned IdxW = (MaxBytes > 1) ? $clog2(MaxBytes) : 1;

    fetch_state_e                  state_q, state_d;
    logic [AddrWidth-1:0]          pc_q, pc_d;
    logic [AddrWidth-1:0]          addr_q, addr_d;
    logic [DataWidth*MaxBytes-1:0] ir_q, ir_d;
    logic [1:0]                    len_q, len_d;
    logic [IdxW-1:0]               idx_q, idx_d;   // next byte slot
    logic [IdxW-1:0]               rem_q, rem_d;   // operand bytes still due
    logic [1:0]                    extra;

    fetch_len_decode #(.MaxBytes(MaxBytes)) u_len_decode (
        .opcode_i (MemData[7:0]),
        .extra_o  (extra)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
    logic [WaitW-1:0] wait_q, wait_d;
    logic             fault_q, fault_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TimeoutCycles != 0);
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        len_d   = len_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
`ifdef FETCH_TIMEOUT_EN
        // Any cycle that is not a further wait (ready, flush, state change)
        // clears the counter.
        wait_d  = '0;
        fault_d = 1'b0;
`endif
        if (!PCLd_n) begin
            // Reload in IDLE, flush everywhere else; a pending DONE strobe is
            // suppressed by the IRLd_n decode below.
            pc_d    = PCIn;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!Fetch_n) begin
                        state_d = OPCODE;
                        addr_d  = pc_q;
                        ir_d    = '0;
                        len_d   = '0;
                        idx_d   = '0;
                        rem_d   = '0;
                    end
                end
                OPCODE, OPERAND: begin
                    if (MemRdy) begin
                        ir_d[idx_q*DataWidth +: DataWidth] = MemData;
                        pc_d   = pc_q + AddrWidth'(1);
                        addr_d = pc_q + AddrWidth'(1);
                        idx_d  = idx_q + IdxW'(1);
                        if (state_q == OPCODE) begin
                            len_d   = extra;
                            rem_d   = IdxW'(extra);
                            state_d = (extra == 2'd0) ? DONE : OPERAND;
                        end else begin
                            rem_d = rem_q - IdxW'(1);
                            if (rem_q == IdxW'(1)) begin
                                state_d = DONE;
                            end
                        end
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (wait_q == WaitW'(TimeoutCycles - 1)) begin
                        state_d = IDLE;
                        fault_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
`endif
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            pc_q    <= ResetVector;
            addr_q  <= ResetVector;
            ir_q    <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end
    assign Fault = fault_q;
`else
    assign Fault = 1'b0;
`endif

    assign Busy    = (state_q == OPCODE) || (state_q == OPERAND);
    assign MemRd_n = !Busy;
    assign MemAddr = addr_q;
    // Strobe is decoded from the state so a reload during DONE can still
    // withhold it in that same cycle.
    assign IRLd_n  = !((state_q == DONE) && PCLd_n);
    assign IRData  = ir_q;
    assign Len     = len_q;
    assign PC      = pc_q;

endmodule
